gpr_dbg_reader: RTL and testbench

//  Debug-side initiator for the GPR file's bus read port: accepts debug commands
//  (single read, block dump, optional write), sequences bus_raddr_o, captures the

---
 rtl/gpr_dbg_reader_pkg.sv | 39 +++
 rtl/gpr_dbg_reader.sv | 203 ++++++++++++++++++++
 tb/tb_gpr_dbg_reader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_dbg_reader_pkg.sv
// Shared types and constants for the debug-side GPR reader.
// RV32E_BASE_ISA selects the 16-entry register file; GPR_DBG_WRITE_EN enables op 10.
package gpr_dbg_reader_pkg;

`ifdef RV32E_BASE_ISA
  localparam int unsigned GprNumDefault = 16;
`else
  localparam int unsigned GprNumDefault = 32;
`endif

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpDump  = 2'b01,
    OpWrite = 2'b10,
    OpRsvd  = 2'b11
  } gdbg_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StRsp   = 2'b11
  } gdbg_state_e;

  function automatic logic op_supported(gdbg_op_e op);
    logic ok;
    unique case (op)
      OpRead, OpDump: ok = 1'b1;
`ifdef GPR_DBG_WRITE_EN
      OpWrite:        ok = 1'b1;
`else
      OpWrite:        ok = 1'b0;
`endif
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/gpr_dbg_reader.sv
// Debug initiator for the GPR bus read port: single reads, block dumps and optional writes.
// Define GPR_DBG_WRITE_EN to enable the write command and the dbg_* write port.
module gpr_dbg_reader
  import gpr_dbg_reader_pkg::*;
#(
  parameter int unsigned NUM_GPR = GprNumDefault,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_cnt_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic [ADDR_W-1:0] bus_raddr_o,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic              dbg_we_o,
  output logic [ADDR_W-1:0] dbg_waddr_o,
  output logic [DATA_W-1:0] dbg_wdata_o,
  input  logic              dbg_wgnt_i
);

  gdbg_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;
  logic              err_q, err_d;

  gdbg_op_e          cmd_op;
  logic              cmd_fire;
  logic [ADDR_W-1:0] eff_cnt;
  logic [ADDR_W:0]   end_idx;
  logic              cmd_reject;

  assign cmd_op      = gdbg_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q == StIdle) && halt_i;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  // Range check in ADDR_W+1 bits so addr+cnt cannot wrap back into range.
  assign eff_cnt    = (cmd_op == OpDump) ? cmd_cnt_i : '0;
  assign end_idx    = {1'b0, cmd_addr_i} + {1'b0, eff_cnt};
  assign cmd_reject = !op_supported(cmd_op) || (32'(end_idx) >= NUM_GPR);

`ifdef GPR_DBG_WRITE_EN
  logic [DATA_W-1:0] wdata_q, wdata_d;
`else
  logic unused_write;
  assign unused_write = ^{dbg_wgnt_i, cmd_wdata_i};
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    err_d       = err_q;
`ifdef GPR_DBG_WRITE_EN
    wdata_d     = wdata_q;
`endif

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_reject) begin
            err_d = 1'b1;
          end else begin
            cur_addr_d  = cmd_addr_i;
            remaining_d = eff_cnt;
            state_d     = StRead;
`ifdef GPR_DBG_WRITE_EN
            wdata_d = cmd_wdata_i;
            if (cmd_op == OpWrite) begin
              if (cmd_addr_i == '0) begin
                // x0 is hardwired: acknowledge without touching the write port.
                rsp_valid_d = 1'b1;
                rsp_addr_d  = '0;
                rsp_data_d  = '0;
                rsp_last_d  = 1'b1;
                state_d     = StRsp;
              end else begin
                state_d = StWrite;
              end
            end
`endif
          end
        end
      end

      StRead: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = cur_addr_q;
        rsp_data_d  = bus_data_i;
        rsp_last_d  = (remaining_q == '0);
        state_d     = StRsp;
      end

      StWrite: begin
`ifdef GPR_DBG_WRITE_EN
        if (dbg_wgnt_i) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          rsp_data_d  = wdata_q;
          rsp_last_d  = 1'b1;
          state_d     = StRsp;
        end
`else
        state_d = StIdle;
`endif
      end

      StRsp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = StIdle;
          end else begin
            cur_addr_d  = cur_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = StRead;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A coincident rejection must not be lost to a clear.
    if (state_q == StIdle && cmd_fire && cmd_reject) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      err_q       <= err_d;
    end
  end

`ifdef GPR_DBG_WRITE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
    end else begin
      wdata_q <= wdata_d;
    end
  end

  assign dbg_we_o    = (state_q == StWrite);
  assign dbg_waddr_o = (state_q == StWrite) ? cur_addr_q : '0;
  assign dbg_wdata_o = (state_q == StWrite) ? wdata_q : '0;
`else
  assign dbg_we_o    = 1'b0;
  assign dbg_waddr_o = '0;
  assign dbg_wdata_o = '0;
`endif

  assign bus_raddr_o = (state_q == StRead) ? cur_addr_q : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_gpr_dbg_reader.sv
// Directed self-checking bench for gpr_dbg_reader with a behavioural register file.
module tb_gpr_dbg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_cnt;
  logic [31:0] cmd_wdata;
  logic [4:0]  bus_raddr;
  logic [31:0] bus_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;
  logic        dbg_wgnt;

  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign bus_data = (bus_raddr == 5'd0) ? 32'h0 : regs[bus_raddr];

  gpr_dbg_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt_i      (halt),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_cnt_i   (cmd_cnt),
    .cmd_wdata_i (cmd_wdata),
    .bus_raddr_o (bus_raddr),
    .bus_data_i  (bus_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_addr_o  (rsp_addr),
    .rsp_data_o  (rsp_data),
    .rsp_last_o  (rsp_last),
    .busy_o      (busy),
    .err_o       (err),
    .err_clr_i   (err_clr),
    .dbg_we_o    (dbg_we),
    .dbg_waddr_o (dbg_waddr),
    .dbg_wdata_o (dbg_wdata),
    .dbg_wgnt_i  (dbg_wgnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] c,
                      input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_cnt   = c;
    cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic l);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_addr"}, rsp_addr, a);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_last"}, rsp_last, l);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int          idx;
    int          cyc;
    logic        stalled;
    logic [4:0]  snap_addr;
    logic [31:0] snap_data;
    logic        snap_last;
    logic [31:0] exp_data;

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0101;
    regs[0] = 32'hFFFF_FFFF;  // must never be visible: x0 reads 0
    regs[5] = 32'h1234_5678;

    rst_n = 1'b0; halt = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
    cmd_cnt = '0; cmd_wdata = '0; rsp_ready = 1'b0; err_clr = 1'b0; dbg_wgnt = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_cmd_ready_nohalt", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_raddr", bus_raddr, 5'd0);
    chk("rst_dbg_we", dbg_we, 1'b0);
    halt = 1'b1;
    #1;
    chk("rst_cmd_ready_halt", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single read of x5
    send(2'b00, 5'd5, 5'd0, 32'h0);
    chk("rd_busy", busy, 1'b1);
    chk("rd_valid_early", rsp_valid, 1'b0);
    chk("rd_raddr", bus_raddr, 5'd5);
    chk("rd_cmd_ready_busy", cmd_ready, 1'b0);
    step();
    chk("rd_valid", rsp_valid, 1'b1);
    chk("rd_addr", rsp_addr, 5'd5);
    chk("rd_data", rsp_data, 32'h1234_5678);
    chk("rd_last", rsp_last, 1'b1);
    chk("rd_raddr_idle", bus_raddr, 5'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_valid_done", rsp_valid, 1'b0);
    chk("rd_busy_done", busy, 1'b0);

    // 2: full dump with a stalling consumer
    send(2'b01, 5'd0, 5'd31, 32'h0);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    snap_addr = '0; snap_data = '0; snap_last = 1'b0;
    while (idx < 32 && cyc < 400) begin
      rsp_ready = ((cyc % 3) != 2);
      if (stalled) begin
        chk("dump_stall_valid", rsp_valid, 1'b1);
        chk("dump_stall_addr", rsp_addr, snap_addr);
        chk("dump_stall_data", rsp_data, snap_data);
        chk("dump_stall_last", rsp_last, snap_last);
      end
      stalled = 1'b0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          exp_data = (idx == 0) ? 32'h0 : regs[idx];
          chk("dump_addr", rsp_addr, idx[4:0]);
          chk("dump_data", rsp_data, exp_data);
          chk("dump_last", rsp_last, (idx == 31));
          idx++;
        end else begin
          stalled = 1'b1;
          snap_addr = rsp_addr;
          snap_data = rsp_data;
          snap_last = rsp_last;
        end
      end
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("dump_count", idx, 32);
    chk("dump_busy_done", busy, 1'b0);

    // 3: out-of-range dump rejected; boundary dump accepted
    send(2'b01, 5'd30, 5'd2, 32'h0);
    chk("oor_err", err, 1'b1);
    chk("oor_busy", busy, 1'b0);
    chk("oor_valid", rsp_valid, 1'b0);
    step();
    chk("oor_busy2", busy, 1'b0);
    err_clr = 1'b1;
    send(2'b11, 5'd0, 5'd0, 32'h0);
    err_clr = 1'b0;
    chk("err_set_wins", err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err, 1'b0);
    send(2'b01, 5'd30, 5'd1, 32'h0);
    chk("edge_err", err, 1'b0);
    expect_rsp("edge0", 5'd30, regs[30], 1'b0);
    expect_rsp("edge1", 5'd31, regs[31], 1'b1);

    // 4: not halted -> nothing accepted; halt drop mid-dump completes
    halt = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'd5;
    #1;
    chk("nohalt_ready", cmd_ready, 1'b0);
    step();
    cmd_valid = 1'b0;
    chk("nohalt_busy", busy, 1'b0);
    step();
    chk("nohalt_valid", rsp_valid, 1'b0);
    halt = 1'b1;
    send(2'b01, 5'd8, 5'd3, 32'h0);
    halt = 1'b0;
    expect_rsp("hd0", 5'd8, regs[8], 1'b0);
    expect_rsp("hd1", 5'd9, regs[9], 1'b0);
    expect_rsp("hd2", 5'd10, regs[10], 1'b0);
    expect_rsp("hd3", 5'd11, regs[11], 1'b1);
    chk("hd_busy_done", busy, 1'b0);
    chk("hd_ready_nohalt", cmd_ready, 1'b0);
    halt = 1'b1;

    // 5: write command
`ifdef GPR_DBG_WRITE_EN
    send(2'b10, 5'd3, 5'd0, 32'hDEAD_BEEF);
    chk("wr_we1", dbg_we, 1'b1);
    chk("wr_waddr", dbg_waddr, 5'd3);
    chk("wr_wdata", dbg_wdata, 32'hDEAD_BEEF);
    step();
    chk("wr_we2", dbg_we, 1'b1);
    step();
    chk("wr_we3", dbg_we, 1'b1);
    chk("wr_valid_wait", rsp_valid, 1'b0);
    dbg_wgnt = 1'b1;
    step();
    dbg_wgnt = 1'b0;
    regs[3] = 32'hDEAD_BEEF;
    chk("wr_we_after", dbg_we, 1'b0);
    expect_rsp("wr", 5'd3, 32'hDEAD_BEEF, 1'b1);
    send(2'b00, 5'd3, 5'd0, 32'h0);
    expect_rsp("rdback", 5'd3, 32'hDEAD_BEEF, 1'b1);
    send(2'b10, 5'd0, 5'd0, 32'hCAFE_F00D);
    chk("wr0_we", dbg_we, 1'b0);
    chk("wr0_valid", rsp_valid, 1'b1);
    expect_rsp("wr0", 5'd0, 32'h0, 1'b1);
    chk("wr0_err", err, 1'b0);
`else
    send(2'b10, 5'd3, 5'd0, 32'hDEAD_BEEF);
    chk("wr_dis_err", err, 1'b1);
    chk("wr_dis_we", dbg_we, 1'b0);
    chk("wr_dis_busy", busy, 1'b0);
    chk("wr_dis_valid", rsp_valid, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wr_dis_clr", err, 1'b0);
`endif

    // 6: reset during a dump response
    send(2'b01, 5'd0, 5'd5, 32'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rstmid_in_rsp", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", rsp_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_addr", rsp_addr, 5'd0);
    chk("rstmid_data", rsp_data, 32'h0);
    chk("rstmid_ready", cmd_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid_idle", busy, 1'b0);
    chk("rstmid_no_rsp", rsp_valid, 1'b0);
    send(2'b00, 5'd5, 5'd0, 32'h0);
    expect_rsp("post_rst", 5'd5, 32'h1234_5678, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
